// File: rtl/aes2_sched_pkg.sv
// Shared types and defaults for the AES2 request scheduler.
package aes2_sched_pkg;

  localparam int DW          = 128;
  localparam int TIMEOUT_DEF = 2048;
  localparam int RCV_CYC_DEF = 4;

  typedef enum logic [2:0] {
    RST_REL,
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    RECOVER
  } state_t;

endpackage

// File: rtl/rr_arb_onehot.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
module rr_arb_onehot #(
  parameter int NREQ = 4,
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [PW-1:0]   gnt_idx,
  output logic            gnt_any
);

  logic [PW-1:0] k;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    k       = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = PW'((int'(rr_ptr) + i) % NREQ);
      if (!gnt_any && req[k]) begin
        gnt_any    = 1'b1;
        gnt_oh[k]  = 1'b1;
        gnt_idx    = k;
      end
    end
  end

endmodule

// File: rtl/aes2_req_sched.sv
// Shares one AES2 engine between NREQ requesters: round-robin grant, latch, start,
// wait for the done edge (or watchdog abort with engine reset), then respond.
module aes2_req_sched
  import aes2_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int RCV_CYC = RCV_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_pc,
  input  logic [NREQ*DW-1:0] req_iv,
  input  logic [NREQ*DW-1:0] req_key,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rsp_vld,
  output logic               rsp_err,
  output logic [DW-1:0]      rsp_data,
  output logic               busy,
  output logic               eng_rst,
  output logic               eng_start,
  output logic [DW-1:0]      eng_pc,
  output logic [DW-1:0]      eng_iv,
  output logic [DW-1:0]      eng_key,
  input  logic               eng_done,
  input  logic [DW-1:0]      eng_ct
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (TIMEOUT > RCV_CYC) ? TIMEOUT : RCV_CYC;
  localparam int WW   = $clog2(CMAX + 1);

  state_t          state_q, state_d;
  logic            done_q;
  logic [WW-1:0]   wdog;
  logic [PW-1:0]   rr_ptr, gidx, ptr_nxt;
  logic [NREQ-1:0] arb_oh;
  logic [PW-1:0]   arb_idx;
  logic            arb_any;
  logic            done_evt, wd_hit, rcv_hit;
  logic            rel_en, latch_en, start_en, cnt_en, rsp_ok, rsp_to, adv, rcv_done;
  logic [DW-1:0]   pc_arr  [NREQ];
  logic [DW-1:0]   iv_arr  [NREQ];
  logic [DW-1:0]   key_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign pc_arr[i]  = req_pc[i*DW +: DW];
    assign iv_arr[i]  = req_iv[i*DW +: DW];
    assign key_arr[i] = req_key[i*DW +: DW];
  end

  rr_arb_onehot #(.NREQ(NREQ)) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  // Only a rising edge counts, so a done level left over from the last op is ignored.
  assign done_evt = eng_done & ~done_q;
  assign wd_hit   = (wdog == WW'(TIMEOUT - 1));
  assign rcv_hit  = (wdog == WW'(RCV_CYC - 1));
  assign ptr_nxt  = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RST_REL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RST_REL: state_d = IDLE;
      IDLE:    if (arb_any) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (done_evt) state_d = RESP;
               else if (wd_hit) state_d = RECOVER;
      RESP:    state_d = IDLE;
      RECOVER: if (rcv_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rel_en   = (state_q == RST_REL);
    latch_en = (state_q == IDLE) && arb_any;
    start_en = (state_q == ISSUE);
    cnt_en   = (state_q == WAIT) || (state_q == RECOVER);
    rsp_ok   = (state_q == WAIT) && done_evt;
    rsp_to   = (state_q == WAIT) && !done_evt && wd_hit;
    adv      = (state_q == RESP) || (state_q == RECOVER);
    rcv_done = (state_q == RECOVER) && rcv_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q    <= 1'b0;
      wdog      <= '0;
      rr_ptr    <= '0;
      gidx      <= '0;
      gnt       <= '0;
      rsp_vld   <= '0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      eng_rst   <= 1'b0;
      eng_start <= 1'b0;
      eng_pc    <= '0;
      eng_iv    <= '0;
      eng_key   <= '0;
    end else begin
      done_q    <= eng_done;
      eng_start <= start_en;
      rsp_vld   <= (rsp_ok || rsp_to) ? gnt : '0;

      if (rel_en || rcv_done) eng_rst <= 1'b1;
      else if (rsp_to)        eng_rst <= 1'b0;

      // The watchdog doubles as the recovery-hold counter.
      if (start_en || rsp_to) wdog <= '0;
      else if (cnt_en)        wdog <= wdog + WW'(1);

      if (rsp_ok)      rsp_data <= eng_ct;
      else if (rsp_to) rsp_data <= '0;

      if (rsp_ok || rsp_to) rsp_err <= rsp_to;
      else if (adv)         rsp_err <= 1'b0;

      if (latch_en) begin
        gnt     <= arb_oh;
        gidx    <= arb_idx;
        eng_pc  <= pc_arr[arb_idx];
        eng_iv  <= iv_arr[arb_idx];
        eng_key <= key_arr[arb_idx];
      end else if (adv) begin
        gnt <= '0;
      end

      if (adv) rr_ptr <= ptr_nxt;

      if (latch_en)                         busy <= 1'b1;
      else if (state_q == RESP || rcv_done) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes2_req_sched.sv
// Directed + randomized bench for aes2_req_sched with a behavioural engine and arbiter model.
module tb_aes2_req_sched;
  import aes2_sched_pkg::*;

  localparam int N = 4;
  localparam logic [127:0] CT_FORCE = 128'hABCDEF01_23456789_0A1B2C3D_4E5F60CD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [N-1:0]     req, req_t;
  logic [N*128-1:0] req_pc, req_iv, req_key;
  logic [127:0]     pc_a [N];
  logic [127:0]     iv_a [N];
  logic [127:0]     key_a [N];

  for (genvar i = 0; i < N; i++) begin : g_pk
    assign req_pc[i*128 +: 128]  = pc_a[i];
    assign req_iv[i*128 +: 128]  = iv_a[i];
    assign req_key[i*128 +: 128] = key_a[i];
  end

  logic [N-1:0] gnt, rsp_vld;
  logic         rsp_err, busy, eng_rst, eng_start;
  logic [127:0] rsp_data, eng_pc, eng_iv, eng_key;
  logic         eng_done = 1'b0;
  logic [127:0] eng_ct = '0;

  logic [N-1:0] t_gnt, t_rsp_vld;
  logic         t_rsp_err, t_busy, t_eng_rst, t_eng_start;
  logic [127:0] t_rsp_data, t_eng_pc, t_eng_iv, t_eng_key;
  logic         t_done = 1'b0;
  logic [127:0] t_ct = '0;

  aes2_req_sched #(.NREQ(N), .TIMEOUT(200), .RCV_CYC(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_pc(req_pc), .req_iv(req_iv), .req_key(req_key),
    .gnt(gnt), .rsp_vld(rsp_vld), .rsp_err(rsp_err), .rsp_data(rsp_data), .busy(busy),
    .eng_rst(eng_rst), .eng_start(eng_start), .eng_pc(eng_pc), .eng_iv(eng_iv),
    .eng_key(eng_key), .eng_done(eng_done), .eng_ct(eng_ct)
  );

  // Second instance with a short watchdog and an engine that never finishes.
  aes2_req_sched #(.NREQ(N), .TIMEOUT(16), .RCV_CYC(4)) dut_to (
    .clk(clk), .rst(rst), .req(req_t), .req_pc(req_pc), .req_iv(req_iv), .req_key(req_key),
    .gnt(t_gnt), .rsp_vld(t_rsp_vld), .rsp_err(t_rsp_err), .rsp_data(t_rsp_data), .busy(t_busy),
    .eng_rst(t_eng_rst), .eng_start(t_eng_start), .eng_pc(t_eng_pc), .eng_iv(t_eng_iv),
    .eng_key(t_eng_key), .eng_done(t_done), .eng_ct(t_ct)
  );

  int total = 0, bad = 0;
  int model_ptr = 0, ops = 0, rsp_cnt = 0;
  bit bad_vld = 0, multi_start = 0;
  int start_run = 0;

  function automatic logic [127:0] fct(input logic [127:0] p, input logic [127:0] iv,
                                       input logic [127:0] k);
    return p ^ {iv[63:0], iv[127:64]} ^ ~k;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Round-robin rule: first requester at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  // Engine model: done rises e_lat cycles after start; sticky mode keeps the
  // previous done level high for a few cycles into the next operation.
  int e_lat = 10, e_cnt = 0, e_hold = 0;
  bit sticky = 0, force_ct = 0;
  logic [127:0] e_ct = '0;
  always @(negedge clk) begin
    if (!eng_rst) begin
      eng_done = 1'b0;
      e_cnt    = 0;
      e_hold   = 0;
    end else if (eng_start) begin
      e_cnt = e_lat;
      e_ct  = force_ct ? CT_FORCE : fct(eng_pc, eng_iv, eng_key);
      if (sticky) e_hold = 5;
      else        eng_done = 1'b0;
    end else begin
      if (e_hold > 0) begin
        e_hold--;
        if (e_hold == 0) eng_done = 1'b0;
      end
      if (e_cnt > 0) begin
        e_cnt--;
        if (e_cnt == 0) begin
          eng_done = 1'b1;
          eng_ct   = e_ct;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rsp_vld != '0) begin
      rsp_cnt++;
      if (((rsp_vld & ~gnt) != '0) || ($countones(rsp_vld) != 1)) bad_vld = 1;
    end
    start_run = eng_start ? start_run + 1 : 0;
    if (start_run > 1) multi_start = 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] r, input bit drop,
                        input bit mutate, output int cyc);
    bit ok, kbad;
    logic [1:0] gi;
    logic [127:0] exp_ct, kkeep;
    req = r; ok = 0; kbad = 0; cyc = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick(1);
      if (gnt != '0) ok = 1;
    end
    chk({tag, "_gnt_seen"}, 128'(ok), 128'(1));
    gi = 2'(pick(r, model_ptr));
    chk({tag, "_gnt"}, 128'(gnt), 128'(4'b0001 << gi));
    chk({tag, "_busy"}, 128'(busy), 128'(1));
    exp_ct = force_ct ? CT_FORCE : fct(pc_a[gi], iv_a[gi], key_a[gi]);
    kkeep  = key_a[gi];
    chk({tag, "_key_latch"}, eng_key, kkeep);
    chk({tag, "_pc_latch"}, eng_pc, pc_a[gi]);
    tick(1);
    chk({tag, "_start"}, 128'(eng_start), 128'(1));
    if (drop) req = '0;
    if (mutate) key_a[gi] = ~kkeep;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick(1);
      cyc++;
      if (rsp_vld != '0) ok = 1;
      else if (eng_key !== kkeep) kbad = 1;
    end
    chk({tag, "_vld_seen"}, 128'(ok), 128'(1));
    chk({tag, "_vld"}, 128'(rsp_vld), 128'(4'b0001 << gi));
    chk({tag, "_err"}, 128'(rsp_err), 128'(0));
    chk({tag, "_data"}, rsp_data, exp_ct);
    chk({tag, "_key_hold"}, 128'(kbad), 128'(0));
    ops++;
    model_ptr = (int'(gi) + 1) % N;
    tick(1);
    chk({tag, "_busy_fall"}, 128'(busy), 128'(0));
    chk({tag, "_gnt_clr"}, 128'(gnt), 128'(0));
    chk({tag, "_vld_pulse"}, 128'(rsp_vld), 128'(0));
  endtask

  initial begin
    int cyc, k, lowc;
    bit ok;
    rst = 1'b1; req = '0; req_t = '0;
    for (int i = 0; i < N; i++) begin
      pc_a[i] = rnd128(); iv_a[i] = rnd128(); key_a[i] = rnd128();
    end
    tick(2);
    chk("rst_gnt", 128'(gnt), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_eng_rst", 128'(eng_rst), 128'(0));
    chk("rst_start", 128'(eng_start), 128'(0));
    chk("rst_vld", 128'(rsp_vld), 128'(0));
    chk("rst_data", rsp_data, 128'(0));
    chk("rst_pc", eng_pc, 128'(0));
    rst = 1'b0;
    tick(1);
    chk("rel_eng_rst", 128'(eng_rst), 128'(1));
    chk("rel_t_eng_rst", 128'(t_eng_rst), 128'(1));

    // Single request with forced ciphertext
    pc_a[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    force_ct = 1; e_lat = 40;
    run_op("single", 4'b0001, 0, 0, cyc);
    chk("single_lat", 128'(cyc >= 40), 128'(1));
    req = '0; force_ct = 0;

    // Async reset mid-operation
    e_lat = 30; req = 4'b0010;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick(1);
      if (gnt != '0) ok = 1;
    end
    chk("arst_gnt_seen", 128'(ok), 128'(1));
    tick(6);
    rst = 1'b1;
    #1;
    chk("arst_gnt", 128'(gnt), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_start", 128'(eng_start), 128'(0));
    chk("arst_eng_rst", 128'(eng_rst), 128'(0));
    tick(2);
    chk("arst_vld", 128'(rsp_vld), 128'(0));
    req = '0; rst = 1'b0; model_ptr = 0;
    tick(1);
    chk("arst_rel", 128'(eng_rst), 128'(1));
    chk("arst_no_rsp", 128'(rsp_cnt), 128'(ops));

    // Fairness with all requesters held
    for (int n = 0; n < 5; n++) begin
      e_lat = 3 + int'($urandom_range(0, 15));
      run_op("fair", 4'b1111, 0, 0, cyc);
    end
    req = '0;

    // Sticky done level across operations
    sticky = 1; e_lat = 20;
    run_op("sticky1", 4'b0100, 0, 0, cyc);
    chk("sticky1_wait", 128'(cyc >= 20), 128'(1));
    run_op("sticky2", 4'b1000, 0, 0, cyc);
    chk("sticky2_wait", 128'(cyc >= 20), 128'(1));
    sticky = 0; req = '0;

    // Randomized requests, data and latency; occasional early deassert
    for (int n = 0; n < 8; n++) begin
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) begin
        pc_a[i] = rnd128(); iv_a[i] = rnd128(); key_a[i] = rnd128();
      end
      r = N'($urandom_range(1, 15));
      e_lat = 3 + int'($urandom_range(0, 25));
      run_op("rand", r, bit'($urandom_range(0, 1)), 0, cyc);
    end
    req = '0;

    // Requester 2 key changes after grant
    key_a[2] = rnd128();
    run_op("mutate", 4'b0100, 0, 1, cyc);
    req = '0;

    // Watchdog abort and recovery
    req_t = 4'b0011; ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick(1);
      if (t_gnt != '0) ok = 1;
    end
    chk("to_gnt_seen", 128'(ok), 128'(1));
    chk("to_gnt", 128'(t_gnt), 128'(4'b0001));
    ok = 0;
    for (int i = 0; i < 5 && !ok; i++) begin
      if (t_eng_start) ok = 1;
      else tick(1);
    end
    chk("to_start_seen", 128'(ok), 128'(1));
    k = 0; ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick(1);
      k++;
      if (t_rsp_vld != '0) ok = 1;
    end
    chk("to_delay", 128'(k), 128'(16));
    chk("to_vld", 128'(t_rsp_vld), 128'(4'b0001));
    chk("to_err", 128'(t_rsp_err), 128'(1));
    chk("to_data", t_rsp_data, 128'(0));
    lowc = 0;
    for (int i = 0; i < 20; i++) begin
      if (t_eng_rst) break;
      lowc++;
      tick(1);
    end
    chk("to_rst_low", 128'(lowc), 128'(4));
    chk("to_busy_fall", 128'(t_busy), 128'(0));
    ok = 0;
    for (int i = 0; i < 5 && !ok; i++) begin
      tick(1);
      if (t_gnt != '0) ok = 1;
    end
    chk("to_next_gnt", 128'(t_gnt), 128'(4'b0010));
    req_t = '0; ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick(1);
      if (!t_busy) ok = 1;
    end
    chk("to_drain", 128'(ok), 128'(1));

    chk("vld_onehot_granted", 128'(bad_vld), 128'(0));
    chk("start_single_pulse", 128'(multi_start), 128'(0));
    chk("rsp_count", 128'(rsp_cnt), 128'(ops));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
